div_sqrt_rec_fn_arbiter: RTL

//  Shares one multi-cycle recoded-FN divide/sqrt-to-raw unit between NUM_REQ requesters.

---
 rtl/div_sqrt_rec_fn_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_sqrt_rec_fn_arbiter.sv
// Round-robin arbiter that shares one recoded divide/sqrt-to-raw unit between NUM_REQ issue lanes.
// It tracks the single op in flight and holds its raw result until the owning lane takes it.
//
// state  | meaning
// IDLE   | nothing in flight, free to issue
// BUSY   | op issued, waiting for the divider result pulse
// RESP   | raw result buffered, waiting for respReady (may issue in the drain cycle)
module div_sqrt_rec_fn_arbiter #(
  parameter  int expWidth = 8,
  parameter  int sigWidth = 24,
  parameter  int NUM_REQ  = 2,
  parameter  int TAG_W    = 4,
  localparam int OP_W     = expWidth + sigWidth + 1,
  localparam int RAW_W    = expWidth + sigWidth + 15
) (
  input  logic                     nReset,
  input  logic                     clock,
  input  logic [NUM_REQ-1:0]       reqValid,
  output logic [NUM_REQ-1:0]       reqReady,
  input  logic [NUM_REQ-1:0]       reqSqrtOp,
  input  logic [NUM_REQ*OP_W-1:0]  reqA,
  input  logic [NUM_REQ*OP_W-1:0]  reqB,
  input  logic [NUM_REQ*3-1:0]     reqRm,
  input  logic [NUM_REQ*TAG_W-1:0] reqTag,
  input  logic                     divInReady,
  output logic                     divInValid,
  output logic                     divSqrtOp,
  output logic [OP_W-1:0]          divA,
  output logic [OP_W-1:0]          divB,
  output logic [2:0]               divRm,
  input  logic                     divOutValid,
  input  logic [RAW_W-1:0]         divRaw,
  output logic                     respValid,
  input  logic                     respReady,
  output logic [NUM_REQ-1:0]       respOwner,
  output logic [TAG_W-1:0]         respTag,
  output logic [RAW_W-1:0]         respRaw,
  output logic                     busy,
  output logic                     protoErr
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_owner;
  logic [TAG_W-1:0]   r_tag;
  logic [RAW_W-1:0]   r_raw;
  logic               r_proto_err;

  logic [PTR_W-1:0]   w_cand;
  logic [PTR_W-1:0]   w_gidx;
  logic               w_found;
  logic               w_any;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_can_issue;
  logic               w_issue;

  // Search from the round-robin pointer upward; outputs stay quiet while reset is held.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && reqValid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
    w_any = w_found & nReset;
    w_grant = '0;
    w_grant[w_gidx] = w_any;
  end

  assign w_can_issue = (r_state == S_IDLE) | ((r_state == S_RESP) & respReady);
  assign divInValid  = w_can_issue & w_any;
  assign w_issue     = divInValid & divInReady;
  assign reqReady    = w_issue ? w_grant : '0;

  assign divSqrtOp = w_any ? reqSqrtOp[w_gidx] : 1'b0;
  assign divA      = w_any ? reqA[int'(w_gidx)*OP_W +: OP_W] : '0;
  assign divB      = w_any ? reqB[int'(w_gidx)*OP_W +: OP_W] : '0;
  assign divRm     = w_any ? reqRm[int'(w_gidx)*3 +: 3] : 3'd0;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_tag       <= '0;
      r_raw       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_issue) begin
        r_owner  <= w_grant;
        r_tag    <= reqTag[int'(w_gidx)*TAG_W +: TAG_W];
        r_rr_ptr <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_issue) r_state <= S_BUSY;
          if (divOutValid) r_proto_err <= 1'b1;
        end
        S_BUSY: begin
          if (divOutValid) begin
            r_raw   <= divRaw;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (respReady) r_state <= w_issue ? S_BUSY : S_IDLE;
          if (divOutValid) r_proto_err <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign respValid = (r_state == S_RESP);
  assign respOwner = r_owner;
  assign respTag   = r_tag;
  assign respRaw   = r_raw;
  assign busy      = (r_state != S_IDLE);
  assign protoErr  = r_proto_err;

endmodule
